top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 218 +++++++++++++++++++++
 tb/tb_top.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top: read-only QSPI flash emulator for a target chip.
// Everything runs on sys_clk. SCK and CSB are synchronised and oversampled.
// Array content is synthetic: the byte at address a is a[7:0].
//
// Ports
//   sys_clk   system clock (the only clock)
//   sys_rst   asynchronous, active-high reset
//   mrn       active-low reset to the target chip
//   mprj_io   target IO bus: [30]=SCK in, [31]=CSB in, [35:32]=SIO[3:0]
//             (bidirectional); all other bits are left undriven
//   Switch    board switches; Switch[0]=1 holds the target in reset
//   LED       last command byte received
//
// Optional feature: define SPI_SINGLE_READ_EN to accept command 0x03.
// This is a single-bit read: 24 address bits on SIO[0], then data on SIO[1].
// -----------------------------------------------------------------------------
module top #(
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned RST_CYCLES = 1024,
    parameter int unsigned DUMMY_CLKS = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        mrn,
    inout  wire  [37:0] mprj_io,
    input  logic [3:0]  Switch,
    output logic [7:0]  LED
);

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_IGNORE
    } state_t;

    localparam int unsigned RCW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [7:0]  DUMMY_LAST = 8'(DUMMY_CLKS - 1);

    // Synchronisers. Bit [2] of the SCK chain is the previous sample.
    // It is used for edge detection.
    logic [2:0] sck_q;
    logic [1:0] csb_q;
    logic [1:0] sw_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sck_q <= '0;
            csb_q <= '1;
            sw_q  <= '0;
        end else begin
            sck_q <= {sck_q[1:0], mprj_io[30]};
            csb_q <= {csb_q[0], mprj_io[31]};
            sw_q  <= {sw_q[0], Switch[0]};
        end
    end

    logic       sck_rise, sck_fall, csb_s;
    logic [3:0] sio_in;
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign csb_s    = csb_q[1];
    assign sio_in   = mprj_io[35:32];

    // Target reset generator
    logic [RCW-1:0] rst_cnt_q;
    logic           mrn_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rst_cnt_q <= '0;
            mrn_q     <= 1'b0;
        end else if (sw_q[1]) begin
            rst_cnt_q <= '0;
            mrn_q     <= 1'b0;
        end else if (!mrn_q) begin
            if (rst_cnt_q == RCW'(RST_CYCLES - 1)) mrn_q <= 1'b1;
            else                                   rst_cnt_q <= rst_cnt_q + 1'b1;
        end
    end

    assign mrn = mrn_q;

    // Flash protocol FSM
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [3:0]        sio_out_q, sio_out_d;
    logic              drive_q, drive_d;
    logic              single_q, single_d;
    logic [7:0]        led_q, led_d;
    logic [7:0]        cur_byte;

    assign cur_byte = addr_q[7:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        sio_out_d = sio_out_q;
        drive_d   = drive_q;
        single_d  = single_q;
        led_d     = led_q;

        if (csb_s) begin
            state_d  = S_CMD;
            cnt_d    = '0;
            drive_d  = 1'b0;
            single_d = 1'b0;
        end else begin
            case (state_q)
                S_CMD: if (sck_rise) begin
                    cmd_d = {cmd_q[6:0], sio_in[0]};
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd7) begin
                        led_d = cmd_d;
                        cnt_d = '0;
                        if (cmd_d == 8'hEB) state_d = S_ADDR;
`ifdef SPI_SINGLE_READ_EN
                        else if (cmd_d == 8'h03) begin
                            state_d  = S_ADDR;
                            single_d = 1'b1;
                        end
`endif
                        else state_d = S_IGNORE;
                    end
                end
                // Address bits are shifted into a MEM_AW-wide register.
                // Bits above MEM_AW simply fall off the top.
                S_ADDR: if (sck_rise) begin
                    cnt_d = cnt_q + 8'd1;
                    if (single_q) begin
                        addr_d = {addr_q[MEM_AW-2:0], sio_in[0]};
                        if (cnt_q == 8'd23) begin
                            state_d = S_DATA;
                            cnt_d   = '0;
                        end
                    end else begin
                        addr_d = {addr_q[MEM_AW-5:0], sio_in};
                        if (cnt_q == 8'd5) begin
                            state_d = S_MODE;
                            cnt_d   = '0;
                        end
                    end
                end
                S_MODE: if (sck_rise) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = (DUMMY_CLKS == 0) ? S_DATA : S_DUMMY;
                        cnt_d   = '0;
                    end
                end
                S_DUMMY: if (sck_rise) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == DUMMY_LAST) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: if (sck_fall) begin
                    drive_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    if (single_q) begin
                        sio_out_d = {2'b00, cur_byte[3'd7 - cnt_q[2:0]], 1'b0};
                        if (cnt_q == 8'd7) begin
                            addr_d = addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
                            cnt_d  = '0;
                        end
                    end else begin
                        sio_out_d = cnt_q[0] ? cur_byte[3:0] : cur_byte[7:4];
                        if (cnt_q[0]) begin
                            addr_d = addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
                            cnt_d  = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_CMD;
            cnt_q     <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            sio_out_q <= '0;
            drive_q   <= 1'b0;
            single_q  <= 1'b0;
            led_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            sio_out_q <= sio_out_d;
            drive_q   <= drive_d;
            single_q  <= single_d;
            led_q     <= led_d;
        end
    end

    assign LED = led_q;

    // Output enable drops combinationally as soon as synchronised CSB rises.
    logic [3:0] sio_oe;
    assign sio_oe = (state_q == S_DATA && drive_q && !csb_s)
                  ? (single_q ? 4'b0010 : 4'b1111) : 4'b0000;

    for (genvar g = 0; g < 4; g++) begin : g_sio
        assign mprj_io[32+g] = sio_oe[g] ? sio_out_q[g] : 1'bz;
    end

    logic unused_in;
    assign unused_in = ^{Switch[3:1], mprj_io[37:36], mprj_io[29:0]};

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top: directed bench for the QSPI flash emulator.
// It acts as the SPI master, mode 0, with SCK period = 10 sys_clk.
// SIO lines carry pull-ups, so a released bus reads back as 4'hF.
// -----------------------------------------------------------------------------
module tb_top;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  Switch  = 4'h0;
    logic        mrn;
    logic [7:0]  LED;
    wire  [37:0] mprj_io;

    logic        sck    = 1'b0;
    logic        csb    = 1'b1;
    logic [3:0]  tb_sio = 4'h0;
    logic [3:0]  tb_oe  = 4'h0;
    logic [3:0]  sio_rd;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    assign mprj_io[30] = sck;
    assign mprj_io[31] = csb;
    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign mprj_io[32+g] = tb_oe[g] ? tb_sio[g] : 1'bz;
        pullup pu (mprj_io[32+g]);
    end
    assign sio_rd = mprj_io[35:32];

    top #(.MEM_AW(10), .RST_CYCLES(1024), .DUMMY_CLKS(4)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .mrn     (mrn),
        .mprj_io (mprj_io),
        .Switch  (Switch),
        .LED     (LED)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic sck_pulse();
        sck = 1'b1;
        tick(5);
        sck = 1'b0;
        tick(5);
    endtask

    task automatic begin_xfer();
        csb = 1'b0;
        tick(5);
    endtask

    task automatic end_xfer();
        tb_oe = 4'h0;
        tick(2);
        csb = 1'b1;
        tick(10);
    endtask

    task automatic send_byte1(input logic [7:0] b);
        tb_oe = 4'b0001;
        for (int i = 7; i >= 0; i--) begin
            tb_sio[0] = b[i];
            sck_pulse();
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        tb_oe  = 4'hF;
        tb_sio = n;
        sck_pulse();
    endtask

    // Samples the bus just before the rising edge, as the master would.
    task automatic read_nib(output logic [3:0] n);
        n = sio_rd;
        sck_pulse();
    endtask

    task automatic quad_start(input logic [23:0] a);
        begin_xfer();
        send_byte1(8'hEB);
        for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
        send_nib(4'h0);
        send_nib(4'h0);
        tb_oe = 4'h0;
        repeat (4) sck_pulse();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  n;
        logic [31:0] exp_q [8];
        logic [15:0] ser;

        // Reset behaviour and target-reset timing
        tick(3);
        check("rst_mrn", 32'(mrn), 32'd0);
        check("rst_led", 32'(LED), 32'h00);
        check("rst_sio", 32'(sio_rd), 32'hF);
        sys_rst = 1'b0;
        tick(1023);
        check("mrn_low_1023", 32'(mrn), 32'd0);
        tick(1);
        check("mrn_high_1024", 32'(mrn), 32'd1);

        // Quad read at 0x000200
        exp_q = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h2, 32'h0, 32'h3};
        quad_start(24'h000200);
        check("led_eb", 32'(LED), 32'hEB);
        for (int i = 0; i < 8; i++) begin
            read_nib(n);
            check($sformatf("q200_nib%0d", i), 32'(n), exp_q[i]);
        end
        check("q200_drv_before_csb", 32'(sio_rd), 32'h0);
        csb = 1'b1;
        tick(3);
        check("hiz_after_csb", 32'(sio_rd), 32'hF);
        tb_oe = 4'h0;
        tick(10);

        // Wrap at the top of the array
        exp_q = '{32'hF, 32'hF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        quad_start(24'h0003FF);
        for (int i = 0; i < 4; i++) begin
            read_nib(n);
            check($sformatf("wrap_nib%0d", i), 32'(n), exp_q[i]);
        end
        end_xfer();

        // Unsupported command stays off the bus
        begin_xfer();
        send_byte1(8'h9F);
        tb_oe = 4'h0;
        for (int i = 0; i < 16; i++) begin
            read_nib(n);
            check($sformatf("9f_hiz%0d", i), 32'(n), 32'hF);
        end
        check("led_9f", 32'(LED), 32'h9F);
        end_xfer();

        // Abort during address, then a fresh read
        begin_xfer();
        send_byte1(8'hEB);
        send_nib(4'h0);
        send_nib(4'h0);
        send_nib(4'h0);
        end_xfer();
        quad_start(24'h000010);
        read_nib(n);
        check("abort_nib0", 32'(n), 32'h1);
        read_nib(n);
        check("abort_nib1", 32'(n), 32'h0);
        end_xfer();

        // Switch-forced target reset
        Switch = 4'h1;
        tick(4);
        check("sw_mrn_low", 32'(mrn), 32'd0);
        tick(10);
        Switch = 4'h0;
        tick(1024);
        check("sw_mrn_low_1024", 32'(mrn), 32'd0);
        tick(10);
        check("sw_mrn_high", 32'(mrn), 32'd1);

        // Single-bit read command 0x03 at 0x000005
        begin_xfer();
        send_byte1(8'h03);
        send_byte1(8'h00);
        send_byte1(8'h00);
        send_byte1(8'h05);
        tb_oe = 4'h0;
        ser = 16'h0506;
        for (int i = 15; i >= 0; i--) begin
            read_nib(n);
`ifdef SPI_SINGLE_READ_EN
            check($sformatf("single_bit%0d", 15 - i), 32'(n), 32'({2'b11, ser[i], 1'b1}));
`else
            check($sformatf("single_hiz%0d", 15 - i), 32'(n), 32'hF);
`endif
        end
        check("led_03", 32'(LED), 32'h03);
        end_xfer();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
